// File: rtl/hid_serializer_pkg.sv
// Types shared by the hidden-vector serializer: state enum and vector shapes.
`include "consts.vh"

package hid_serializer_pkg;

   localparam int HID_DIM = `HID_DIM;
   localparam int N_LEN   = `N_LEN;

   typedef enum logic [1:0] {
      ST_IDLE = `HID_ST_IDLE,
      ST_SEND = `HID_ST_SEND,
      ST_DONE = `HID_ST_DONE
   } hid_state_e;

   typedef logic [N_LEN-1:0]              hid_elem_t;
   typedef logic [HID_DIM-1:0][N_LEN-1:0] hid_vec_t;

endpackage

// File: rtl/hid_serializer_if.sv
// Run/valid control plus element stream of the hidden-vector serializer.
// The chksum signal exists only when HID_SER_CHKSUM_EN is defined.
`include "consts.vh"

interface hid_serializer_if #(
   parameter int IDX_W = 6
) ();
   import hid_serializer_pkg::*;

   logic                     run;
   logic                     valid;
   logic [HID_DIM*N_LEN-1:0] d;
   hid_elem_t                m_data;
   logic                     m_valid;
   logic                     m_ready;
   logic [IDX_W-1:0]         m_idx;
   logic                     m_last;
`ifdef HID_SER_CHKSUM_EN
   hid_elem_t                chksum;
`endif

   // serializer side
   modport master (
      input  run, d, m_ready,
      output valid, m_data, m_valid, m_idx, m_last
`ifdef HID_SER_CHKSUM_EN
      , output chksum
`endif
   );

   // requester / stream consumer side
   modport slave (
      output run, d, m_ready,
      input  valid, m_data, m_valid, m_idx, m_last
`ifdef HID_SER_CHKSUM_EN
      , input chksum
`endif
   );

endinterface

// File: rtl/consts.vh
// Shared constants for the hidden-vector datapath and the serializer's state
// encodings, so the controller and the bench agree on them.
`ifndef HID_CONSTS_VH
`define HID_CONSTS_VH

`define HID_DIM 16
`define N_LEN   16
`define I_LEN   8
`define F_LEN   8

`define HID_ST_IDLE 2'd0
`define HID_ST_SEND 2'd1
`define HID_ST_DONE 2'd2

`endif

// File: rtl/hid_serializer_elem_mux.sv
// Selects element idx out of the snapshot buffer. Written as a compare loop so
// an index wider than log2(HID_DIM) needs no truncation; out-of-range indices
// (unreachable) yield zero.
`include "consts.vh"

module hid_elem_mux
   import hid_serializer_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  hid_vec_t         snap,
   input  logic [IDX_W-1:0] idx,
   output hid_elem_t        elem
);

   // one-hot style selection over all buffered elements
   always_comb begin
      elem = '0;
      for (int i = 0; i < HID_DIM; i++)
         if (idx == IDX_W'(i)) elem = snap[i];
   end

endmodule

// File: rtl/hid_serializer.sv
// Hidden-vector serializer: snapshots a packed HID_DIM x N_LEN vector when run
// is seen in IDLE, streams it one element per valid/ready beat, then raises
// valid until run drops. Optional macro HID_SER_CHKSUM_EN adds a running XOR
// of the transferred elements on bus.chksum.
`include "consts.vh"

module hid_serializer
   import hid_serializer_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input logic                clk,
   input logic                rst_n,
   hid_serializer_if.master   bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HID_DIM-1);

   hid_state_e       state, state_nxt;
   hid_vec_t         snap;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             load, beat;
   hid_elem_t        elem;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;

   // next state, index and strobes; dropping run always wins over a beat
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      beat      = 1'b0;
      case (state)
         ST_IDLE: if (bus.run) begin
            state_nxt = ST_SEND;
            load      = 1'b1;
            idx_nxt   = '0;
         end
         ST_SEND: if (!bus.run) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
         end else if (bus.m_ready) begin
            beat = 1'b1;
            if (idx == LAST_IDX) begin
               state_nxt = ST_DONE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end
         ST_DONE: if (!bus.run) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // element index and snapshot buffer; buffer survives aborts
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx  <= '0;
         snap <= '0;
      end else begin
         idx <= idx_nxt;
         if (load) snap <= bus.d;
      end

   hid_elem_mux #(.IDX_W(IDX_W)) u_mux (
      .snap (snap),
      .idx  (idx),
      .elem (elem)
   );

   assign bus.m_valid = (state == ST_SEND);
   assign bus.valid   = (state == ST_DONE);
   assign bus.m_idx   = idx;
   assign bus.m_data  = elem;
   assign bus.m_last  = bus.m_valid & (idx == LAST_IDX);

`ifdef HID_SER_CHKSUM_EN
   hid_elem_t chk;

   // running XOR of accepted beats; cleared at start and on return to IDLE
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                                chk <= '0;
      else if (load || state_nxt == ST_IDLE)     chk <= '0;
      else if (beat)                             chk <= chk ^ elem;

   assign bus.chksum = chk;
`endif

endmodule
